// File: rtl/svm_gate_sequencer.sv
// Space-vector gate sequencer: decodes SVM sector/vector strobes into a
// target switch vector and drives complementary per-phase gate pairs with
// dead-time insertion, enable gating and a sticky fault shutdown.
// Bit [i] of every 3-bit vector belongs to phase i+1. Vectors written as
// "abc" in SVM notation map to {c, b, a}, so "110" is 3'b011 here.
module svm_gate_sequencer #(
  parameter int DEAD_W    = 8,
  parameter int DEAD_TIME = 16   // legal range 1 .. 2**DEAD_W-1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] SECTOR,
  input  logic       U_0,
  input  logic       U_1,
  input  logic       U_2,
  input  logic       U_7,
  input  logic       ENABLE,
  input  logic       FAULT,
  input  logic       CLEAR,
  output logic [2:0] HIGH,
  output logic [2:0] LOW,
  output logic [2:0] STATE,
  output logic       BUSY,
  output logic       FAULT_LATCHED,
  output logic       SECTOR_ERR
);

  typedef enum logic [1:0] {
    PH_OFF    = 2'd0,
    PH_DRV_LO = 2'd1,
    PH_DRV_HI = 2'd2,
    PH_DEAD   = 2'd3
  } phase_e;

  // Counter value loaded on DEAD entry; the phase leaves DEAD on the edge
  // where the counter reads zero, giving exactly DEAD_TIME idle cycles.
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_TIME - 1);
  localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);

  logic [2:0]        target_q, target_d;
  logic              sector_err_q, sector_err_d;
  logic              fault_latched_q, fault_latched_d;
  logic              run_ok;
  phase_e            ph_q   [3];
  phase_e            ph_d   [3];
  logic [DEAD_W-1:0] cnt_q  [3];
  logic [DEAD_W-1:0] cnt_d  [3];
  logic [2:0]        dead;

  // Active vectors per sector: second=0 -> U_1 vector, second=1 -> U_2 vector.
  function automatic logic [2:0] active_vector(input logic [2:0] sector,
                                               input logic       second);
    logic [2:0] v;
    case (sector)
      3'd0:    v = second ? 3'b011 : 3'b001;  // 110 / 100
      3'd1:    v = second ? 3'b011 : 3'b010;  // 110 / 010
      3'd2:    v = second ? 3'b110 : 3'b010;  // 011 / 010
      3'd3:    v = second ? 3'b110 : 3'b100;  // 011 / 001
      3'd4:    v = second ? 3'b101 : 3'b100;  // 101 / 001
      3'd5:    v = second ? 3'b101 : 3'b001;  // 101 / 100
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // Target decode with strobe priority U_7 > U_0 > U_2 > U_1; no strobe holds.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    target_d     = target_q;
    sector_err_d = 1'b0;
    if (U_7) begin
      target_d = 3'b111;
    end else if (U_0) begin
      target_d = 3'b000;
    end else if (U_2 || U_1) begin
      if (SECTOR[2:1] != 2'b11) begin
        target_d = active_vector(SECTOR, U_2);
      end else begin
        sector_err_d = 1'b1;
      end
    end
  end

  // Sticky fault: FAULT sets it, CLEAR only wins while FAULT is low.
  always_comb begin
    fault_latched_d = FAULT | (fault_latched_q & ~CLEAR);
    // Using the next flag value lets a fault kill the gates on the same edge
    // the flag is set, and a clear restart dead time on the edge it clears.
    run_ok          = ENABLE & ~fault_latched_d;
  end

  // Per-phase next-state and dead-time counter; each phase runs independently.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ph_d[i]  = ph_q[i];
      cnt_d[i] = cnt_q[i];
      if (!run_ok) begin
        ph_d[i]  = PH_OFF;
        cnt_d[i] = '0;
      end else begin
        case (ph_q[i])
          PH_OFF: begin
            ph_d[i]  = PH_DEAD;
            cnt_d[i] = DEAD_LOAD;
          end
          PH_DRV_LO: begin
            if (target_q[i]) begin
              ph_d[i]  = PH_DEAD;
              cnt_d[i] = DEAD_LOAD;
            end
          end
          PH_DRV_HI: begin
            if (!target_q[i]) begin
              ph_d[i]  = PH_DEAD;
              cnt_d[i] = DEAD_LOAD;
            end
          end
          PH_DEAD: begin
            // Target changes inside the window are ignored until it expires;
            // the level is chosen from the target seen on the final cycle.
            if (cnt_q[i] == '0) begin
              ph_d[i] = target_q[i] ? PH_DRV_HI : PH_DRV_LO;
            end else begin
              cnt_d[i] = cnt_q[i] - DEAD_ONE;
            end
          end
          default: begin
            ph_d[i]  = PH_OFF;
            cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // State registers; asynchronous reset returns every phase to OFF.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample their inputs from the same pre-edge values.
    if (RST) begin
      target_q        <= 3'b000;
      sector_err_q    <= 1'b0;
      fault_latched_q <= 1'b0;
      // NOTE: the dead-time counters are small flop arrays, not memories,
      // so they are reset alongside the FSM state.
      for (int i = 0; i < 3; i++) begin
        ph_q[i]  <= PH_OFF;
        cnt_q[i] <= '0;
      end
    end else begin
      target_q        <= target_d;
      sector_err_q    <= sector_err_d;
      fault_latched_q <= fault_latched_d;
      for (int i = 0; i < 3; i++) begin
        ph_q[i]  <= ph_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Gate outputs decoded from registered state: HIGH and LOW are never
  // asserted together because each comes from a distinct state encoding.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      HIGH[i] = (ph_q[i] == PH_DRV_HI);
      LOW[i]  = (ph_q[i] == PH_DRV_LO);
      dead[i] = (ph_q[i] == PH_DEAD);
    end
    STATE         = HIGH;
    BUSY          = |dead;
    FAULT_LATCHED = fault_latched_q;
    SECTOR_ERR    = sector_err_q;
  end

endmodule

// File: tb/tb_svm_gate_sequencer.sv
// Scoreboard bench for svm_gate_sequencer with DEAD_TIME=4. The stimulus
// process pushes the expected output word for each cycle it steps; a
// separate monitor on the falling edge pops and compares, and also checks
// that HIGH and LOW never overlap.
module tb_svm_gate_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] sector;
  logic       u0, u1, u2, u7;
  logic       enable, fault, clear;
  logic [2:0] high, low, state;
  logic       busy, fault_latched, sector_err;

  svm_gate_sequencer #(.DEAD_W(8), .DEAD_TIME(4)) dut (
    .CLK          (clk),
    .RST          (rst),
    .SECTOR       (sector),
    .U_0          (u0),
    .U_1          (u1),
    .U_2          (u2),
    .U_7          (u7),
    .ENABLE       (enable),
    .FAULT        (fault),
    .CLEAR        (clear),
    .HIGH         (high),
    .LOW          (low),
    .STATE        (state),
    .BUSY         (busy),
    .FAULT_LATCHED(fault_latched),
    .SECTOR_ERR   (sector_err)
  );

  // Expected word layout: {STATE, HIGH, LOW, BUSY, FAULT_LATCHED, SECTOR_ERR}
  typedef struct {
    int          cyc;
    string       name;
    logic [11:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   compared = 0;
  int   failed   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] dut_word();
    return {state, high, low, busy, fault_latched, sector_err};
  endfunction

  task automatic check(input string name, input logic [11:0] act,
                       input logic [11:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @cyc %0d: got %b required %b", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input logic [2:0] hi,
                      input logic [2:0] lo, input logic bsy,
                      input logic flt, input logic err);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.exp  = {hi, hi, lo, bsy, flt, err};
    exp_q.push_back(e);
  endtask

  // One clock edge, then record what the outputs must be for that cycle.
  task automatic step(input string name, input logic [2:0] hi,
                      input logic [2:0] lo, input logic bsy,
                      input logic flt, input logic err);
    tick();
    push(name, hi, lo, bsy, flt, err);
  endtask

  task automatic strobes(input logic s0, input logic s1, input logic s2,
                         input logic s7);
    u0 = s0; u1 = s1; u2 = s2; u7 = s7;
  endtask

  // Monitor: overlap invariant every cycle, then retire due expectations.
  always @(negedge clk) begin
    check("no_overlap", {9'b0, high & low}, 12'b0);
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        if (exp_q[i].cyc != cyc) begin
          compared++;
          failed++;
          $display("FAIL %s: expectation for cyc %0d missed (now %0d)",
                   exp_q[i].name, exp_q[i].cyc, cyc);
        end else begin
          check(exp_q[i].name, dut_word(), exp_q[i].exp);
        end
        exp_q.delete(i);
      end
    end
  end

  initial begin
    rst = 1'b1; sector = 3'd0; strobes(0, 0, 0, 0);
    enable = 1'b0; fault = 1'b0; clear = 1'b0;

    // Reset state.
    tick();
    step("reset", 3'b000, 3'b000, 0, 0, 0);
    rst = 1'b0;

    // Enable: dead window on all phases, then drive target 000 low.
    enable = 1'b1;
    repeat (4) step("en_dead", 3'b000, 3'b000, 1, 0, 0);
    step("en_lo", 3'b000, 3'b111, 0, 0, 0);

    // U_1, sector 0 -> 3'b001: phase 1 drops a cycle after target update.
    sector = 3'd0; strobes(0, 1, 0, 0);
    step("s0u1_tgt", 3'b000, 3'b111, 0, 0, 0);
    strobes(0, 0, 0, 0);
    repeat (4) step("s0u1_dead", 3'b000, 3'b110, 1, 0, 0);
    step("s0u1_hi", 3'b001, 3'b110, 0, 0, 0);

    // U_1 and U_2 together, sector 3: U_2 wins -> 3'b110, all phases change.
    sector = 3'd3; strobes(0, 1, 1, 0);
    step("s3u12_tgt", 3'b001, 3'b110, 0, 0, 0);
    strobes(0, 0, 0, 0);
    repeat (4) step("s3u12_dead", 3'b000, 3'b000, 1, 0, 0);
    step("s3u12_drv", 3'b110, 3'b001, 0, 0, 0);

    // U_0 and U_7 together: U_7 wins -> 111, only phase 1 changes.
    strobes(1, 0, 0, 1);
    step("u07_tgt", 3'b110, 3'b001, 0, 0, 0);
    strobes(0, 0, 0, 0);
    repeat (4) step("u07_dead", 3'b110, 3'b000, 1, 0, 0);
    step("u07_drv", 3'b111, 3'b000, 0, 0, 0);

    // Illegal sector with U_2: one-cycle error pulse, gates unchanged.
    sector = 3'd6; strobes(0, 0, 1, 0);
    step("sec6_err", 3'b111, 3'b000, 0, 0, 1);
    strobes(0, 0, 0, 0);
    step("sec6_after", 3'b111, 3'b000, 0, 0, 0);

    // Back to 000 via U_0 with an illegal sector (still legal for U_0).
    strobes(1, 0, 0, 0);
    step("u0_tgt", 3'b111, 3'b000, 0, 0, 0);
    strobes(0, 0, 0, 0);
    repeat (4) step("u0_dead", 3'b000, 3'b000, 1, 0, 0);
    step("u0_lo", 3'b000, 3'b111, 0, 0, 0);

    // Phase-1 target 0 -> 1 -> 0 in two cycles: full dead window, back low.
    sector = 3'd0; strobes(0, 1, 0, 0);
    step("tog_up", 3'b000, 3'b111, 0, 0, 0);
    strobes(1, 0, 0, 0);
    step("tog_dead", 3'b000, 3'b110, 1, 0, 0);
    strobes(0, 0, 0, 0);
    repeat (3) step("tog_dead", 3'b000, 3'b110, 1, 0, 0);
    step("tog_lo", 3'b000, 3'b111, 0, 0, 0);

    // Fault during dead time, CLEAR blocked while FAULT high, then cleared.
    strobes(0, 1, 0, 0);
    step("f_tgt", 3'b000, 3'b111, 0, 0, 0);
    strobes(0, 0, 0, 0);
    step("f_dead", 3'b000, 3'b110, 1, 0, 0);
    fault = 1'b1;
    step("f_set", 3'b000, 3'b000, 0, 1, 0);
    clear = 1'b1;
    step("f_clr_blocked", 3'b000, 3'b000, 0, 1, 0);
    fault = 1'b0; clear = 1'b0;
    step("f_sticky", 3'b000, 3'b000, 0, 1, 0);
    clear = 1'b1;
    step("f_cleared", 3'b000, 3'b000, 1, 0, 0);
    clear = 1'b0;
    repeat (3) step("f_redead", 3'b000, 3'b000, 1, 0, 0);
    step("f_drv", 3'b001, 3'b110, 0, 0, 0);

    // ENABLE low forces all phases off; re-enable restarts dead time.
    enable = 1'b0;
    step("dis_off", 3'b000, 3'b000, 0, 0, 0);
    enable = 1'b1;
    repeat (4) step("reen_dead", 3'b000, 3'b000, 1, 0, 0);
    step("reen_drv", 3'b001, 3'b110, 0, 0, 0);

    // Asynchronous reset in the middle of a dead window.
    strobes(1, 0, 0, 0);
    step("r_tgt", 3'b001, 3'b110, 0, 0, 0);
    strobes(0, 0, 0, 0);
    tick();
    check("pre_rst", dut_word(), {3'b000, 3'b000, 3'b110, 3'b100});
    #2 rst = 1'b1;
    #1 check("async_rst", dut_word(), 12'b0);
    step("rst_hold", 3'b000, 3'b000, 0, 0, 0);
    rst = 1'b0;

    // Randomised strobes/ENABLE/FAULT; the monitor checks non-overlap.
    for (int n = 0; n < 400; n++) begin
      sector = 3'($urandom_range(0, 7));
      strobes(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      enable = ($urandom_range(0, 15) != 0);
      fault  = ($urandom_range(0, 39) == 0);
      clear  = ($urandom_range(0, 7) == 0);
      tick();
    end
    strobes(0, 0, 0, 0); fault = 1'b0; clear = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) tick();
    while (exp_q.size() != 0) begin
      compared++;
      failed++;
      $display("FAIL %s: expectation for cyc %0d never checked",
               exp_q[0].name, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/svm_gate_sequencer.md
# svm_gate_sequencer

Parametrised space-vector switch sequencer for the three-phase AC motor inverter. It decodes the sector and vector strobes from the SVM timing logic into a target switch vector. It drives complementary high-side/low-side gate signals per phase with programmable dead-time insertion, enable gating and a latched fault shutdown. It sits between the SVM vector timer and the gate-driver pins.

## Interface
Parameters:
- DEAD_W, 8, width of the dead-time counter
- DEAD_TIME, 16, dead-time length in CLK cycles; legal range 1 .. 2^DEAD_W-1

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- SECTOR  in  3  current SVM sector, 0..5 legal
- U_0  in  1  strobe: select zero vector 000
- U_1  in  1  strobe: select first active vector of sector
- U_2  in  1  strobe: select second active vector of sector
- U_7  in  1  strobe: select zero vector 111
- ENABLE  in  1  1 = gates may be driven
- FAULT  in  1  external fault, level-sensitive
- CLEAR  in  1  clears latched fault (ignored while FAULT=1)
- HIGH  out  3  high-side gate per phase [0]=phase 1
- LOW  out  3  low-side gate per phase
- STATE  out  3  vector actually driven (bit=1 where HIGH=1)
- BUSY  out  1  any phase in dead time
- FAULT_LATCHED  out  1  sticky fault flag
- SECTOR_ERR  out  1  one-cycle pulse on strobe with SECTOR 6/7

## Operation
- Target decode, registered into TARGET[2:0] (reset 000). Priority U_7 > U_0 > U_2 > U_1; no strobe = hold.
- Active vectors (U_1 / U_2): S0 100/110, S1 010/110, S2 010/011, S3 001/011, S4 001/101, S5 100/101.
- U_1/U_2 with SECTOR 6 or 7: TARGET held, SECTOR_ERR=1 for one cycle. U_0/U_7 are legal with any SECTOR.
- Per-phase FSM, states OFF, DRV_LO, DRV_HI, DEAD. Reset: OFF.
  - OFF: HIGH=LOW=0. Leaves for DEAD when ENABLE=1 and FAULT_LATCHED=0.
  - DRV_LO: LOW=1, HIGH=0.
  - DRV_HI: HIGH=1, LOW=0.
  - DRV_LO or DRV_HI with the phase's TARGET bit differing from the driven level: go to DEAD.
  - DEAD: HIGH=LOW=0. Loads counter with DEAD_TIME-1 on entry and decrements each cycle. At count 0 it goes to DRV_HI or DRV_LO per the TARGET bit sampled at that cycle.
  - TARGET toggling during DEAD does not restart or shorten dead time. A phase whose target returns to its previous level still completes dead time.
- ENABLE=0 or FAULT_LATCHED=1 forces every phase to OFF from any state, including DEAD. The counter is discarded.
- FAULT=1 sets FAULT_LATCHED. The flag is cleared by RST, or by CLEAR=1 while FAULT=0. FAULT and CLEAR asserted together: latch stays set.
- Invariant: HIGH[i] & LOW[i] = 0 in every cycle, including reset and transitions.
- BUSY = OR of per-phase DEAD. STATE = HIGH.

## Timing
- Reset values: HIGH=000, LOW=000, STATE=000, BUSY=0, FAULT_LATCHED=0, SECTOR_ERR=0, TARGET=000, all phases OFF.
- Strobe at edge n: TARGET updates at n+1. The changed phases' outputs drop at n+2. The new level is driven at n+2+DEAD_TIME.
- SECTOR_ERR is asserted at n+1 for exactly one cycle.
- ENABLE rising at edge n: all phases enter DEAD at n+1 and drive TARGET at n+1+DEAD_TIME.
- FAULT high at edge n: FAULT_LATCHED=1 at n+1 and all gates 0 at n+1.
- Unchanged phases are unaffected by a vector change; each phase sequences independently.
- RST mid-operation: all outputs go to 0 immediately (asynchronous).

## Test plan
- DEAD_TIME=4, enabled, TARGET=000, phases in DRV_LO. Pulse U_1 with SECTOR=0 -> LOW[0] falls 2 cycles later; HIGH[0]=1 4 cycles after that; phases 2 and 3 keep LOW=1 throughout.
- Same cycle U_1=U_2=1, SECTOR=3 -> TARGET=011. U_0 and U_7 together -> TARGET=111.
- SECTOR=6 with U_2 -> SECTOR_ERR one-cycle pulse, TARGET and gates unchanged.
- Toggle phase-1 target 0->1->0 within 2 cycles -> one full 4-cycle dead window, then LOW[0]=1, HIGH[0] never asserted.
- FAULT pulse during DEAD -> all gates 0 next cycle and FAULT_LATCHED=1. CLEAR with FAULT=1 has no effect. CLEAR after FAULT=0 -> flag clears, then a 4-cycle dead window before gates drive.
- Assert RST asynchronously mid-DEAD -> all outputs 0 without a clock edge. Randomised strobes/ENABLE run -> HIGH&LOW never overlap.
